// File: rtl/y86_seq_controller.sv
// Sequencing controller for the sequential Y86-64 core: walks each instruction
// through its stages, owns the architectural PC, status code and retire count.
module y86_seq_controller #(
    parameter logic [63:0] START_PC    = 64'd0,
    parameter int          MEM_TIMEOUT = 16,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic [63:0]      valC,
    input  logic [63:0]      valP,
    input  logic             halt_prog,
    input  logic             is_instruction_valid,
    input  logic             pcvalid,
    input  logic             cnd,
    input  logic [63:0]      valM,
    input  logic             mem_ready,
    input  logic             mem_error,
    output logic [63:0]      PC,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             memory_en,
    output logic             writeback_en,
    output logic [2:0]       Stat,
    output logic             running,
    output logic [CNT_W-1:0] retired
);

    localparam int TMO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_PCUPD     = 3'd6,
        ST_HALTED    = 3'd7
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [2:0]       stat_r;
    logic [2:0]       stat_next_s;
    logic             retire_s;
    logic [63:0]      pc_r;
    logic [63:0]      valm_r;
    logic [TMO_W-1:0] tmo_r;
    logic [4:0]       en_r;
    logic             running_r;
    logic [CNT_W-1:0] retired_r;

    function automatic logic [63:0] next_pc_f(input logic [3:0] ic, input logic c,
                                              input logic [63:0] vc, input logic [63:0] vp,
                                              input logic [63:0] vm);
        logic [63:0] r;
        case (ic)
            4'd8:    r = vc;
            4'd7:    r = c ? vc : vp;
            4'd9:    r = vm;
            default: r = vp;
        endcase
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc_f(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    // Ordered {fetch, decode, execute, memory, writeback}.
    function automatic logic [4:0] stage_en_f(input state_t s);
        logic [4:0] r;
        case (s)
            ST_FETCH:     r = 5'b10000;
            ST_DECODE:    r = 5'b01000;
            ST_EXECUTE:   r = 5'b00100;
            ST_MEMORY:    r = 5'b00010;
            ST_WRITEBACK: r = 5'b00001;
            default:      r = 5'b00000;
        endcase
        return r;
    endfunction

    // Next state, next status and retire decision.
    always_comb begin
        state_next_s = state_r;
        stat_next_s  = stat_r;
        retire_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FETCH:   state_next_s = ST_DECODE;
            ST_DECODE: begin
                if (pcvalid) begin
                    state_next_s = ST_HALTED;
                    stat_next_s  = STAT_ADR;
                end else if (!is_instruction_valid) begin
                    state_next_s = ST_HALTED;
                    stat_next_s  = STAT_INS;
                end else if (halt_prog) begin
                    state_next_s = ST_HALTED;
                    stat_next_s  = STAT_HLT;
                    retire_s     = 1'b1;
                end else begin
                    state_next_s = ST_EXECUTE;
                end
            end
            ST_EXECUTE: state_next_s = ST_MEMORY;
            ST_MEMORY: begin
                if (mem_ready) begin
                    if (mem_error) begin
                        state_next_s = ST_HALTED;
                        stat_next_s  = STAT_ADR;
                    end else begin
                        state_next_s = ST_WRITEBACK;
                    end
                end else if (tmo_r == TMO_LAST) begin
                    state_next_s = ST_HALTED;
                    stat_next_s  = STAT_ADR;
                end else begin
                    state_next_s = ST_MEMORY;
                end
            end
            ST_WRITEBACK: state_next_s = ST_PCUPD;
            ST_PCUPD: begin
                retire_s = 1'b1;
                if (start) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_HALTED:  state_next_s = ST_HALTED;
            default:    state_next_s = ST_IDLE;
        endcase
    end

    // Controller state, PC, status and counters; strobes registered from next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            stat_r    <= STAT_AOK;
            pc_r      <= START_PC;
            valm_r    <= 64'd0;
            tmo_r     <= {TMO_W{1'b0}};
            en_r      <= 5'b00000;
            running_r <= 1'b0;
            retired_r <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_next_s;
            stat_r    <= stat_next_s;
            en_r      <= stage_en_f(state_next_s);
            running_r <= (state_next_s != ST_IDLE) && (state_next_s != ST_HALTED);
            // Counter is only live while waiting in MEMORY, so it is clear on entry.
            if (state_r == ST_MEMORY && !mem_ready) begin
                tmo_r <= tmo_r + TMO_W'(1);
            end else begin
                tmo_r <= {TMO_W{1'b0}};
            end
            if (state_r == ST_MEMORY && mem_ready && !mem_error) begin
                valm_r <= valM;
            end
            if (state_r == ST_PCUPD) begin
                pc_r <= next_pc_f(icode, cnd, valC, valP, valm_r);
            end
            if (retire_s) begin
                retired_r <= sat_inc_f(retired_r);
            end
        end
    end

    assign PC           = pc_r;
    assign Stat         = stat_r;
    assign running      = running_r;
    assign retired      = retired_r;
    assign fetch_en     = en_r[4];
    assign decode_en    = en_r[3];
    assign execute_en   = en_r[2];
    assign memory_en    = en_r[1];
    assign writeback_en = en_r[0];

endmodule

// File: doc/y86_seq_controller.md
Name: y86_seq_controller

Overview:
- Sequencing controller for the single-cycle-per-stage Y86-64 sequential core.
- Steps one instruction at a time through FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PCUPD by issuing a one-hot stage enable per stage.
- Owns the architectural PC and computes the next PC from the fetch, execute and memory results.
- Maintains the Y86 status code (Stat), stops the core on halt, invalid instruction, address error or memory timeout, and counts retired instructions.

Parameters:
- START_PC, 64'd0, PC loaded on reset.
- MEM_TIMEOUT, 16, maximum cycles spent in MEMORY waiting for mem_ready before an address error is raised.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level; begins or continues execution from IDLE.
- icode  in  4  instruction class from fetch, valid in DECODE and later states.
- valC  in  64  constant word from fetch.
- valP  in  64  fall-through PC from fetch.
- halt_prog  in  1  fetch flag: halt instruction decoded.
- is_instruction_valid  in  1  fetch flag: icode is legal.
- pcvalid  in  1  fetch flag, 1 = PC out of range.
- cnd  in  1  branch condition from execute, valid in MEMORY and later states.
- valM  in  64  memory read data, valid when mem_ready=1.
- mem_ready  in  1  memory access complete.
- mem_error  in  1  data-memory address error, sampled with mem_ready.
- PC  out  64  current architectural PC.
- fetch_en, decode_en, execute_en, memory_en, writeback_en  out  1 each  one-hot stage strobes.
- Stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- running  out  1  high outside IDLE and HALTED.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset values (applied on the clk edge while reset=1, any state): state=IDLE, PC=START_PC, Stat=AOK, retired=0, all stage enables=0, running=0, timeout counter=0. Reset mid-instruction abandons that instruction; no PC or retired update occurs.
- Stage enables are decoded from state: exactly one high in FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK; none in IDLE, PCUPD, HALTED.
- IDLE -> FETCH when start=1; otherwise stay in IDLE.
- FETCH -> DECODE after 1 cycle. Fetch registers its outputs on that edge.
- DECODE: sample the fetch flags, in priority order:
  - pcvalid=1 -> Stat=ADR, go to HALTED.
  - is_instruction_valid=0 -> Stat=INS, go to HALTED.
  - halt_prog=1 -> Stat=HLT, retired+1, go to HALTED.
  - Otherwise go to EXECUTE.
- EXECUTE -> MEMORY after 1 cycle.
- MEMORY: hold memory_en=1 until mem_ready=1; the timeout counter increments each waiting cycle.
  - If mem_ready=1 and mem_error=1 -> Stat=ADR, go to HALTED.
  - If mem_ready=1 and mem_error=0 -> capture valM, go to WRITEBACK.
  - If the counter reaches MEM_TIMEOUT with no mem_ready -> Stat=ADR, go to HALTED.
  - The counter clears on entry to MEMORY.
  - Minimum MEMORY dwell is 1 cycle, i.e. mem_ready already high on the first cycle.
- WRITEBACK -> PCUPD after 1 cycle.
- PCUPD: PC <= next PC, retired <= retired+1. Go to FETCH if start=1, else IDLE.
- Next-PC selection:
  - icode=8 (call): valC.
  - icode=7 (jxx) with cnd=1: valC.
  - icode=9 (ret): captured valM.
  - All other icodes: valP.
  - All PC arithmetic is 64-bit unsigned with wrap; no overflow check beyond pcvalid.
- HALTED:
  - Sticky: PC and Stat hold, and start is ignored.
  - Only reset leaves HALTED.
  - The PC is not advanced on halt or error, so it points at the faulting or halt instruction.
- Latency: 6 cycles per instruction with a 1-cycle memory stage; +N for N wait cycles.
- retired saturates at all-ones.
- Simultaneous pcvalid=1 and halt_prog=1: ADR wins, per the priority order.

Test Plan:
- Reset, start=1, icode=6 with valP=2, mem_ready=1 -> after 6 cycles PC=2, retired=1; enable order fetch, decode, execute, memory, writeback, then none.
- icode=7, valC=0x40, cnd=1 -> PC=0x40. Same instruction with cnd=0, valP=9 -> PC=9.
- icode=8, valC=0x100 -> PC=0x100. Then icode=9 with valM=0x0B returned after 3 wait cycles -> PC=0x0B; that instruction takes 9 cycles.
- halt_prog=1 at PC=0x10 -> Stat=2, PC stays 0x10, running=0, retired incremented; start toggling has no effect; reset -> Stat=1, PC=START_PC.
- is_instruction_valid=0 -> Stat=4. Separately, pcvalid=1 together with halt_prog=1 -> Stat=3.
- mem_ready held low for MEM_TIMEOUT=16 cycles -> Stat=3 and HALTED. Separately, reset asserted during MEMORY -> IDLE next cycle, retired unchanged.
